// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Holds operands steady for SETTLE_CYCLES edges, captures the result and returns it to the owner.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | no operation in flight; grant offered to one valid requester
//  S_WAIT | operands driven to the ALU, settle counter running down
//  S_RESP | result captured, RSP_VALID high for owner until it is consumed
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid0_i,
    input  logic       req_valid1_i,
    output logic       req_ready0_o,
    output logic       req_ready1_o,
    input  logic [2:0] req_op0_i,
    input  logic [2:0] req_op1_i,
    input  logic [7:0] req_data1_0_i,
    input  logic [7:0] req_data2_0_i,
    input  logic [7:0] req_data1_1_i,
    input  logic [7:0] req_data2_1_i,
    output logic       rsp_valid0_o,
    output logic       rsp_valid1_o,
    input  logic       rsp_ready0_i,
    input  logic       rsp_ready1_i,
    output logic [7:0] rsp_result_o,
    output logic       rsp_zero_o,
    output logic [7:0] alu_data1_o,
    output logic [7:0] alu_data2_o,
    output logic [2:0] alu_select_o,
    input  logic [7:0] alu_result_i,
    input  logic       alu_zero_i,
    output logic       busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       owner_q;
    logic       lg_q;
    logic [2:0] op_q;
    logic [7:0] data1_q;
    logic [7:0] data2_q;
    logic [7:0] result_q;
    logic       zero_q;
    logic       rsp_valid0_q;
    logic       rsp_valid1_q;
    logic       gnt0;
    logic       gnt1;

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_ni && state_q == S_IDLE) begin
            if (req_valid0_i && (!req_valid1_i || lg_q)) begin
                gnt0 = 1'b1;
            end else if (req_valid1_i) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            lg_q         <= 1'b1;
            op_q         <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner_q <= gnt1;
                        op_q    <= gnt1 ? req_op1_i     : req_op0_i;
                        data1_q <= gnt1 ? req_data1_1_i : req_data1_0_i;
                        data2_q <= gnt1 ? req_data2_1_i : req_data2_0_i;
                        cnt_q   <= SETTLE_LD;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The edge that takes the counter to zero is the capture edge.
                    if (cnt_q <= 4'd1) begin
                        cnt_q        <= '0;
                        result_q     <= alu_result_i;
                        zero_q       <= alu_zero_i;
                        rsp_valid0_q <= !owner_q;
                        rsp_valid1_q <= owner_q;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if ((rsp_valid0_q && rsp_ready0_i) || (rsp_valid1_q && rsp_ready1_i)) begin
                        lg_q         <= owner_q;
                        rsp_valid0_q <= 1'b0;
                        rsp_valid1_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready0_o = gnt0;
    assign req_ready1_o = gnt1;
    assign rsp_valid0_o = rsp_valid0_q;
    assign rsp_valid1_o = rsp_valid1_q;
    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;
    assign alu_data1_o  = data1_q;
    assign alu_data2_o  = data2_q;
    assign alu_select_o = op_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: models the shared ALU and checks arbitration, latency,
// back-pressure and reset abort against a transaction-level reference.
module tb_alu_arbiter;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic       ready0, ready1;
    logic [2:0] op0 = '0, op1 = '0;
    logic [7:0] d1_0 = '0, d2_0 = '0, d1_1 = '0, d2_1 = '0;
    logic       rsp_valid0, rsp_valid1;
    logic       rsp_ready0 = 1'b0, rsp_ready1 = 1'b0;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic [7:0] alu_d1, alu_d2;
    logic [2:0] alu_sel;
    logic [7:0] alu_res;
    logic       alu_zero;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_lg = 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        int sh;
        sh = int'(b[2:0]);
        case (op)
            3'd0: return a;
            3'd1: return a + b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: begin p = 16'(a) * 16'(b); return p[7:0]; end
            3'd5: return a << sh;
            3'd6: return 8'($signed(a) >>> sh);
            default: return (a << sh) | (a >> (8 - sh));
        endcase
    endfunction

    assign alu_res  = alu_f(alu_sel, alu_d1, alu_d2);
    assign alu_zero = (alu_res == 8'h00);

    alu_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid0_i(valid0), .req_valid1_i(valid1),
        .req_ready0_o(ready0), .req_ready1_o(ready1),
        .req_op0_i(op0), .req_op1_i(op1),
        .req_data1_0_i(d1_0), .req_data2_0_i(d2_0),
        .req_data1_1_i(d1_1), .req_data2_1_i(d2_1),
        .rsp_valid0_o(rsp_valid0), .rsp_valid1_o(rsp_valid1),
        .rsp_ready0_i(rsp_ready0), .rsp_ready1_i(rsp_ready1),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
        .alu_data1_o(alu_d1), .alu_data2_o(alu_d2), .alu_select_o(alu_sel),
        .alu_result_i(alu_res), .alu_zero_i(alu_zero),
        .busy_o(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_lg = 1;
        tick();
    endtask

    task automatic wait_rsp(input int idx, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if ((idx == 0 && rsp_valid0) || (idx == 1 && rsp_valid1)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        valid0 = 1'b1; valid1 = 1'b1;
        tick();
        checks++;
        if ({ready0, ready1, rsp_valid0, rsp_valid1, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 00000", {ready0, ready1, rsp_valid0, rsp_valid1, busy});
        end
        checks++;
        if ({rsp_result, rsp_zero} !== 9'h0) begin
            errors++; $display("FAIL reset_rsp: got %h/%b exp 00/0", rsp_result, rsp_zero);
        end
        checks++;
        if ({alu_d1, alu_d2, alu_sel} !== 19'h0) begin
            errors++; $display("FAIL reset_alu: got %h %h %b exp 00 00 000", alu_d1, alu_d2, alu_sel);
        end
        valid0 = 1'b0; valid1 = 1'b0;
        rst_n = 1'b1;
        model_lg = 1;
        tick();
    endtask

    task automatic test_add();
        int n;
        op0 = 3'd1; d1_0 = 8'h05; d2_0 = 8'h03; valid0 = 1'b1;
        #1;
        checks++;
        if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
            errors++; $display("FAIL add_grant: got %b%b exp 10", ready0, ready1);
        end
        tick();
        valid0 = 1'b0;
        #1;
        checks++;
        if (alu_d1 !== 8'h05 || alu_d2 !== 8'h03 || alu_sel !== 3'd1 || busy !== 1'b1 || ready0 !== 1'b0) begin
            errors++; $display("FAIL add_drive: got %h %h %b busy %b rdy %b exp 05 03 001 1 0", alu_d1, alu_d2, alu_sel, busy, ready0);
        end
        wait_rsp(0, n);
        checks++;
        if (n != S) begin
            errors++; $display("FAIL add_latency: got %0d exp %0d", n, S);
        end
        checks++;
        if (rsp_result !== 8'h08 || rsp_zero !== 1'b0 || rsp_valid1 !== 1'b0) begin
            errors++; $display("FAIL add_result: got %h/%b v1 %b exp 08/0 v1 0", rsp_result, rsp_zero, rsp_valid1);
        end
        rsp_ready0 = 1'b1;
        tick();
        rsp_ready0 = 1'b0;
        model_lg = 0;
        checks++;
        if (rsp_valid0 !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL add_consume: got v0 %b busy %b exp 0 0", rsp_valid0, busy);
        end
    endtask

    task automatic test_tie();
        int n;
        pulse_reset();
        op0 = 3'd2; d1_0 = 8'hF0; d2_0 = 8'h3C;
        op1 = 3'd3; d1_1 = 8'h0F; d2_1 = 8'h30;
        valid0 = 1'b1; valid1 = 1'b1;
        #1;
        checks++;
        if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
            errors++; $display("FAIL tie_first: got %b%b exp 10", ready0, ready1);
        end
        tick();
        valid0 = 1'b0;
        #1;
        checks++;
        if (ready1 !== 1'b0) begin
            errors++; $display("FAIL tie_wait_ready: got %b exp 0", ready1);
        end
        wait_rsp(0, n);
        checks++;
        if (n != S || rsp_result !== 8'h30) begin
            errors++; $display("FAIL tie_rsp0: got lat %0d res %h exp %0d 30", n, rsp_result, S);
        end
        rsp_ready0 = 1'b1;
        tick();
        rsp_ready0 = 1'b0;
        model_lg = 0;
        checks++;
        if (ready1 !== 1'b1 || ready0 !== 1'b0) begin
            errors++; $display("FAIL tie_second: got %b%b exp 01", ready0, ready1);
        end
        tick();
        valid1 = 1'b0;
        wait_rsp(1, n);
        checks++;
        if (n != S || rsp_result !== 8'h3F || rsp_valid0 !== 1'b0) begin
            errors++; $display("FAIL tie_rsp1: got lat %0d res %h v0 %b exp %0d 3f 0", n, rsp_result, rsp_valid0, S);
        end
        rsp_ready1 = 1'b1;
        tick();
        rsp_ready1 = 1'b0;
        model_lg = 1;
    endtask

    task automatic test_alternate();
        int last_t, grants, who, exp_who, owner;
        logic [7:0] exp_res;
        op0 = 3'($urandom_range(0, 7)); d1_0 = 8'($urandom); d2_0 = 8'($urandom);
        op1 = 3'($urandom_range(0, 7)); d1_1 = 8'($urandom); d2_1 = 8'($urandom);
        valid0 = 1'b1; valid1 = 1'b1; rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
        #1;
        last_t = -1; grants = 0; owner = -1;
        for (int g = 0; g < 200 && grants < 4; g++) begin
            if (rsp_valid0 || rsp_valid1) begin
                exp_res = (owner == 1) ? alu_f(op1, d1_1, d2_1) : alu_f(op0, d1_0, d2_0);
                checks++;
                if (rsp_valid0 !== (owner == 0) || rsp_valid1 !== (owner == 1) || rsp_result !== exp_res) begin
                    errors++; $display("FAIL alt_rsp: got v%b%b res %h exp owner %0d res %h", rsp_valid0, rsp_valid1, rsp_result, owner, exp_res);
                end
            end
            if (ready0 || ready1) begin
                who = ready1 ? 1 : 0;
                exp_who = (model_lg == 1) ? 0 : 1;
                checks++;
                if (who != exp_who || (ready0 && ready1)) begin
                    errors++; $display("FAIL alt_grant: got %b%b exp requester %0d", ready0, ready1, exp_who);
                end
                if (last_t >= 0) begin
                    checks++;
                    if (cyc - last_t != S + 2) begin
                        errors++; $display("FAIL alt_spacing: got %0d exp %0d", cyc - last_t, S + 2);
                    end
                end
                last_t = cyc; owner = who; model_lg = who; grants++;
            end
            tick();
        end
        checks++;
        if (grants != 4) begin
            errors++; $display("FAIL alt_count: got %0d exp 4", grants);
        end
        valid0 = 1'b0; valid1 = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL alt_drain: got busy %b exp 0", busy);
        end
        rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        op1 = 3'd1; d1_1 = 8'hFF; d2_1 = 8'h01; valid1 = 1'b1;
        #1;
        checks++;
        if (ready1 !== 1'b1) begin
            errors++; $display("FAIL bp_grant: got %b exp 1", ready1);
        end
        tick();
        valid1 = 1'b0;
        rsp_ready0 = 1'b1;
        wait_rsp(1, n);
        checks++;
        if (n != S) begin
            errors++; $display("FAIL bp_latency: got %0d exp %0d", n, S);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid1 !== 1'b1 || rsp_valid0 !== 1'b0 || rsp_result !== 8'h00 || rsp_zero !== 1'b1 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d: got v%b%b res %h z %b busy %b exp v01 00 1 1", i, rsp_valid0, rsp_valid1, rsp_result, rsp_zero, busy);
            end
            tick();
        end
        rsp_ready0 = 1'b0;
        rsp_ready1 = 1'b1;
        tick();
        rsp_ready1 = 1'b0;
        model_lg = 1;
        checks++;
        if (busy !== 1'b0 || rsp_valid1 !== 1'b0) begin
            errors++; $display("FAIL bp_consume: got busy %b v1 %b exp 0 0", busy, rsp_valid1);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        bit seen;
        op0 = 3'd3; d1_0 = 8'h11; d2_0 = 8'h22; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin
            errors++; $display("FAIL abort_async: got busy %b v%b%b exp 0 00", busy, rsp_valid0, rsp_valid1);
        end
        tick();
        rst_n = 1'b1;
        model_lg = 1;
        rsp_ready0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid0 || rsp_valid1 || busy) seen = 1'b1;
        end
        rsp_ready0 = 1'b0;
        checks++;
        if (seen) begin
            errors++; $display("FAIL abort_no_rsp: got activity 1 exp 0");
        end
        op0 = 3'd1; d1_0 = 8'h10; d2_0 = 8'h22; valid0 = 1'b1;
        #1;
        checks++;
        if (ready0 !== 1'b1) begin
            errors++; $display("FAIL abort_next_grant: got %b exp 1", ready0);
        end
        tick();
        valid0 = 1'b0;
        wait_rsp(0, n);
        checks++;
        if (n != S || rsp_result !== 8'h32) begin
            errors++; $display("FAIL abort_next_rsp: got lat %0d res %h exp %0d 32", n, rsp_result, S);
        end
        rsp_ready0 = 1'b1;
        tick();
        rsp_ready0 = 1'b0;
        model_lg = 0;
    endtask

    task automatic test_non_owner();
        int n;
        op0 = 3'd4; d1_0 = 8'h03; d2_0 = 8'h05; valid0 = 1'b1;
        rsp_ready1 = 1'b1;
        tick();
        valid0 = 1'b0;
        wait_rsp(0, n);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid0 !== 1'b1 || rsp_valid1 !== 1'b0 || rsp_result !== 8'h0F || busy !== 1'b1) begin
                errors++; $display("FAIL nonowner_hold%0d: got v%b%b res %h busy %b exp v10 0f 1", i, rsp_valid0, rsp_valid1, rsp_result, busy);
            end
            tick();
        end
        rsp_ready1 = 1'b0;
        rsp_ready0 = 1'b1;
        tick();
        rsp_ready0 = 1'b0;
        model_lg = 0;
    endtask

    task automatic test_random();
        bit         pend[2];
        logic [2:0] rop[2];
        logic [7:0] ra[2], rb[2];
        int         who, n, hold;
        logic [7:0] exp_res;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1;
                    rop[r] = 3'($urandom_range(0, 7)); ra[r] = 8'($urandom); rb[r] = 8'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                who = int'($urandom_range(0, 1));
                pend[who] = 1'b1;
                rop[who] = 3'($urandom_range(0, 7)); ra[who] = 8'($urandom); rb[who] = 8'($urandom);
            end
            valid0 = pend[0]; op0 = rop[0]; d1_0 = ra[0]; d2_0 = rb[0];
            valid1 = pend[1]; op1 = rop[1]; d1_1 = ra[1]; d2_1 = rb[1];
            #1;
            if (pend[0] && pend[1]) who = (model_lg == 1) ? 0 : 1;
            else who = pend[1] ? 1 : 0;
            checks++;
            if (ready0 !== (who == 0) || ready1 !== (who == 1)) begin
                errors++; $display("FAIL rnd_grant%0d: got %b%b exp requester %0d", t, ready0, ready1, who);
            end
            tick();
            pend[who] = 1'b0;
            if (who == 0) valid0 = 1'b0; else valid1 = 1'b0;
            if (who == 0) rsp_ready1 = 1'($urandom_range(0, 1));
            else rsp_ready0 = 1'($urandom_range(0, 1));
            wait_rsp(who, n);
            exp_res = alu_f(rop[who], ra[who], rb[who]);
            checks++;
            if (n != S || rsp_result !== exp_res || rsp_zero !== (exp_res == 8'h00)) begin
                errors++; $display("FAIL rnd_rsp%0d: got lat %0d res %h z %b exp %0d %h %b", t, n, rsp_result, rsp_zero, S, exp_res, exp_res == 8'h00);
            end
            hold = int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) begin
                tick();
                checks++;
                if (rsp_result !== exp_res || (who == 0 ? rsp_valid0 : rsp_valid1) !== 1'b1 || ready0 !== 1'b0 || ready1 !== 1'b0) begin
                    errors++; $display("FAIL rnd_hold%0d: got res %h v%b%b rdy %b%b exp %h owner %0d", t, rsp_result, rsp_valid0, rsp_valid1, ready0, ready1, exp_res, who);
                end
            end
            rsp_ready0 = (who == 0); rsp_ready1 = (who == 1);
            tick();
            rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
            model_lg = who;
            checks++;
            if (busy !== 1'b0 || rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin
                errors++; $display("FAIL rnd_consume%0d: got busy %b v%b%b exp 0 00", t, busy, rsp_valid0, rsp_valid1);
            end
        end
        valid0 = 1'b0; valid1 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_tie();
        test_alternate();
        test_backpressure();
        test_reset_abort();
        test_non_owner();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, is the number of clock cycles operands are held on the ALU before the result is sampled (legal range 1..15).
REQ-002 CLK  input  1  system clock, all state updates on rising edge.
REQ-003 RESET_N  input  1  one clock; reset is asynchronous and active-low.
REQ-004 REQ_VALID0 / REQ_VALID1  input  1  requester 0 / 1 has an operation pending.
REQ-005 REQ_READY0 / REQ_READY1  output  1  arbiter accepts the requester's operation this cycle.
REQ-006 REQ_OP0 / REQ_OP1  input  3  ALU select code (000 fwd, 001 add, 010 and, 011 or, 100 mul, 101 shift, 110 arith shift, 111 rotate).
REQ-007 REQ_DATA1_0, REQ_DATA2_0 / REQ_DATA1_1, REQ_DATA2_1  input  8  operands per requester.
REQ-008 RSP_VALID0 / RSP_VALID1  output  1  result for that requester is available.
REQ-009 RSP_READY0 / RSP_READY1  input  1  requester consumes the result.
REQ-010 RSP_RESULT  output  8  captured ALU result, shared by both requesters.
REQ-011 RSP_ZERO  output  1  captured ALU ZERO flag, passed through unmodified.
REQ-012 ALU_DATA1, ALU_DATA2  output  8  operands to the shared ALU.
REQ-013 ALU_SELECT  output  3  operation select to the shared ALU.
REQ-014 ALU_RESULT  input  8; ALU_ZERO  input  1  outputs of the shared ALU.
REQ-015 BUSY  output  1  high in every state except IDLE.

Function
REQ-016 The block SHALL implement states IDLE, WAIT, RESP.
REQ-017 In IDLE, REQ_READYn SHALL be high only for the granted requester; grant is combinational from REQ_VALID0/1 and a last-grant pointer LG.
REQ-018 Grant rule SHALL be: only one valid -> that one; both valid -> the requester not equal to LG; none valid -> no READY.
REQ-019 A transfer SHALL occur on a rising edge with VALIDn and READYn both high; op, operands and owner id are registered, a settle counter loads SETTLE_CYCLES, state -> WAIT.
REQ-020 ALU_DATA1, ALU_DATA2, ALU_SELECT SHALL be driven only from the registered values and hold them unchanged outside transfers.
REQ-021 In WAIT, the counter SHALL decrement each edge; on the edge where it reaches 0, ALU_RESULT and ALU_ZERO are captured into RSP_RESULT/RSP_ZERO, state -> RESP.
REQ-022 Latency SHALL be exactly SETTLE_CYCLES edges from transfer edge to the edge that sets RSP_VALIDn.
REQ-023 In RESP, RSP_VALIDn SHALL be high only for the owner; RSP_RESULT/RSP_ZERO stay stable until consumed.
REQ-024 On an edge with RSP_VALIDn and RSP_READYn high, LG SHALL be set to the owner, RSP_VALIDn cleared, state -> IDLE; a new request is accepted no earlier than the following edge.
REQ-025 Both REQ_READY SHALL be low in WAIT and RESP; requests arriving then wait without loss.
REQ-026 RSP_READYn of the non-owner SHALL be ignored; RSP_READYn outside RESP SHALL be ignored.
REQ-027 Sustained throughput SHALL be one operation per SETTLE_CYCLES+2 cycles with immediate RSP_READY.

Reset
REQ-028 While RESET_N is low: state IDLE, all REQ_READY and RSP_VALID low, BUSY low, RSP_RESULT 0x00, RSP_ZERO 0, ALU_DATA1/2 0x00, ALU_SELECT 000, counter 0, LG = 1 (requester 0 wins first tie).
REQ-029 Reset asserted in WAIT or RESP SHALL abort the operation; no response is ever issued for it.

Verification
REQ-030 Req0 op 001, 0x05, 0x03, SETTLE 2 -> REQ_READY0 high, RSP_VALID0 after 2 edges, RSP_RESULT 0x08, RSP_ZERO 0.
REQ-031 Both valid after reset, req0 op 010 0xF0,0x3C; req1 op 011 0x0F,0x30 -> req0 served first (0x30), then req1 (0x3F).
REQ-032 Both held valid continuously for 4 ops -> grants alternate 0,1,0,1.
REQ-033 Req1 op 001 0xFF,0x01 with RSP_READY1 low 5 cycles -> RSP_VALID1 high, RSP_RESULT 0x00, RSP_ZERO 1 stable all 5 cycles; BUSY high until consumed.
REQ-034 RESET_N low for 1 cycle during WAIT -> RSP_VALID never asserts, BUSY low, next req0 accepted normally.
REQ-035 Req0 op 100 0x03,0x05 with RSP_READY1 high and RSP_READY0 low -> stays in RESP, result 0x0F held.
